// File: rtl/flex_down_counter_if.sv
// flex_down_counter_if: control/status bundle for the loadable down-counter.
// The master side (a control FSM) loads and gates the interval; the slave
// side (the counter) reports remaining count, busy/done levels and expiry.
interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    busy;
  logic                    done;
  logic                    expire_flag;

  modport master (
    output clear, load, load_val, count_enable,
    input  count_out, busy, done, expire_flag
  );

  modport slave (
    input  clear, load, load_val, count_enable,
    output count_out, busy, done, expire_flag
  );
endinterface

// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable down-counter that times an interval of
// load_val enabled cycles and pulses expire_flag on the last one.
// Optional macro FLEX_DOWN_COUNTER_AUTO_RELOAD_EN selects periodic mode
// (reload and keep running on expiry); without it the counter is one-shot
// and parks in DONE until the next load, clear or rst.
module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  flex_down_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

  state_t                  state_reg;
  logic [NUM_CNT_BITS-1:0] count_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    expire_reg;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
  // Interval length remembered from the last load, used to restart each period.
  logic [NUM_CNT_BITS-1:0] reload_reg;
`endif

  // Single FSM: rst/clear, then load, then enabled decrement; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      expire_reg <= 1'b0;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else if (bus.load) begin
      // A load always suppresses expiry, even when it lands on the expiry edge.
      expire_reg <= 1'b0;
      done_reg   <= 1'b0;
      if (bus.load_val != '0) begin
        state_reg <= RUN;
        count_reg <= bus.load_val;
        busy_reg  <= 1'b1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_reg <= bus.load_val;
`endif
      end else begin
        // A zero-length interval is treated as "nothing to time".
        state_reg <= IDLE;
        count_reg <= '0;
        busy_reg  <= 1'b0;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_reg <= '0;
`endif
      end
    end else begin
      expire_reg <= 1'b0;
      // count_enable only matters while running, so IDLE/DONE never underflow.
      if (state_reg == RUN && bus.count_enable) begin
        if (count_reg <= CNT_ONE) begin
          expire_reg <= 1'b1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
          count_reg  <= reload_reg;
`else
          state_reg  <= DONE;
          count_reg  <= '0;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
`endif
        end else begin
          count_reg <= count_reg - CNT_ONE;
        end
      end
    end
  end

  assign bus.count_out   = count_reg;
  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.expire_flag = expire_reg;

endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: directed checks of reset, one-shot / periodic expiry,
// gapped enables, restart, priority and edge interval lengths.
// Honours FLEX_DOWN_COUNTER_AUTO_RELOAD_EN the same way as the design.
module tb_flex_down_counter;

  localparam int W = 4;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  flex_down_counter_if #(.NUM_CNT_BITS(W)) bus ();

  flex_down_counter #(.NUM_CNT_BITS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare {count_out, busy, done, expire_flag} against the expected tuple.
  task automatic chk(input string tag, input logic [W-1:0] c, input logic b,
                     input logic d, input logic e);
    logic [W+2:0] obs;
    logic [W+2:0] expv;
    obs  = {bus.count_out, bus.busy, bus.done, bus.expire_flag};
    expv = {c, b, d, e};
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s: observed cnt=%0d busy=%b done=%b exp=%b, expected cnt=%0d busy=%b done=%b exp=%b",
               tag, obs[W+2:3], obs[2], obs[1], obs[0], c, b, d, e);
      end
    $display("check %s: cnt=%0d busy=%b done=%b exp=%b", tag, obs[W+2:3], obs[2], obs[1], obs[0]);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus.clear        = 1'b0;
    bus.load         = 1'b1;
    bus.load_val     = 4'd5;
    bus.count_enable = 1'b0;

    // Reset dominates a concurrent load.
    tick(); chk("reset_c1", 4'd0, 0, 0, 0);
    tick(); chk("reset_c2", 4'd0, 0, 0, 0);
    rst = 1'b0; bus.load = 1'b0;
    tick(); chk("idle", 4'd0, 0, 0, 0);

`ifndef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    // One-shot interval of 3.
    do_load(4'd3); chk("os_load3", 4'd3, 1, 0, 0);
    bus.count_enable = 1'b1;
    tick(); chk("os_2", 4'd2, 1, 0, 0);
    tick(); chk("os_1", 4'd1, 1, 0, 0);
    tick(); chk("os_expire", 4'd0, 0, 1, 1);
    tick(); chk("os_done_hold1", 4'd0, 0, 1, 0);
    tick(); chk("os_done_hold2", 4'd0, 0, 1, 0);
    bus.count_enable = 1'b0;
`else
    // Periodic interval of 2.
    do_load(4'd2); chk("ar_load2", 4'd2, 1, 0, 0);
    bus.count_enable = 1'b1;
    tick(); chk("ar_1a", 4'd1, 1, 0, 0);
    tick(); chk("ar_exp_a", 4'd2, 1, 0, 1);
    tick(); chk("ar_1b", 4'd1, 1, 0, 0);
    tick(); chk("ar_exp_b", 4'd2, 1, 0, 1);
    tick(); chk("ar_1c", 4'd1, 1, 0, 0);
    tick(); chk("ar_exp_c", 4'd2, 1, 0, 1);
    bus.count_enable = 1'b0;
`endif

    // Gapped enable: 1,0,0,1,1,0,1 from a load of 4.
    do_load(4'd4); chk("gap_load4", 4'd4, 1, 0, 0);
    bus.count_enable = 1'b1; tick(); chk("gap_e1", 4'd3, 1, 0, 0);
    bus.count_enable = 1'b0; tick(); chk("gap_e0a", 4'd3, 1, 0, 0);
    tick(); chk("gap_e0b", 4'd3, 1, 0, 0);
    bus.count_enable = 1'b1; tick(); chk("gap_e2", 4'd2, 1, 0, 0);
    tick(); chk("gap_e3", 4'd1, 1, 0, 0);
    bus.count_enable = 1'b0; tick(); chk("gap_e0c", 4'd1, 1, 0, 0);
    bus.count_enable = 1'b1; tick();
    chk("gap_expire", AUTO ? 4'd4 : 4'd0, AUTO, !AUTO, 1);
    bus.count_enable = 1'b0;

    // Restart mid-run, then clear beats a simultaneous load.
    do_load(4'd5); chk("rs_load5", 4'd5, 1, 0, 0);
    bus.count_enable = 1'b1;
    tick(); chk("rs_4", 4'd4, 1, 0, 0);
    tick(); chk("rs_3", 4'd3, 1, 0, 0);
    do_load(4'd7); chk("rs_load7", 4'd7, 1, 0, 0);
    bus.clear = 1'b1;
    do_load(4'd9); chk("clr_vs_load", 4'd0, 0, 0, 0);
    bus.clear = 1'b0;

    // Load on the expiry edge: load wins, no pulse.
    bus.count_enable = 1'b0;
    do_load(4'd1); chk("le_load1", 4'd1, 1, 0, 0);
    bus.count_enable = 1'b1;
    do_load(4'd6); chk("load_vs_expiry", 4'd6, 1, 0, 0);

    // Clear on the expiry edge: clear wins.
    bus.count_enable = 1'b0;
    do_load(4'd1); chk("ce_load1", 4'd1, 1, 0, 0);
    bus.count_enable = 1'b1; bus.clear = 1'b1;
    tick(); chk("clear_vs_expiry", 4'd0, 0, 0, 0);
    bus.clear = 1'b0;

    // Load of 0 from RUN goes IDLE with no flag; enables then ignored.
    bus.count_enable = 1'b0;
    do_load(4'd3); chk("z_load3", 4'd3, 1, 0, 0);
    do_load(4'd0); chk("z_load0", 4'd0, 0, 0, 0);
    bus.count_enable = 1'b1;
    tick(); chk("z_idle_en", 4'd0, 0, 0, 0);

    // Load 1 expires on the first enabled edge.
    bus.count_enable = 1'b0;
    do_load(4'd1); chk("one_load", 4'd1, 1, 0, 0);
    bus.count_enable = 1'b1;
    tick(); chk("one_expire", AUTO ? 4'd1 : 4'd0, AUTO, !AUTO, 1);

    // Load 15: exactly 15 enabled edges to expiry.
    do_load(4'd15); chk("max_load", 4'd15, 1, 0, 0);
    for (int i = 14; i >= 1; i--) begin
      tick();
      chk($sformatf("max_%0d", i), 4'(i), 1, 0, 0);
    end
    tick(); chk("max_expire", AUTO ? 4'd15 : 4'd0, AUTO, !AUTO, 1);
    tick(); chk("max_after", AUTO ? 4'd14 : 4'd0, AUTO, !AUTO, 0);

    // Load 0 from DONE / RUN returns to IDLE.
    do_load(4'd0); chk("final_load0", 4'd0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
